// File: rtl/ioctl_upload_responder.sv
// rtl/ioctl_upload_responder.sv - serves hps_io upload reads from a game core RAM port
//
// Purpose: while hps_io uploads (core -> HPS) with ioctl_index == INDEX, halts the
// game core, then answers each ioctl_rd with a byte from the core's RAM second port
// (or 8'hFF outside SIZE), pacing hps_io with ioctl_wait. Every output is registered.
//
// Ports:
//   clk, reset_n              system clock, asynchronous active-low reset
//   ioctl_upload/index/rd/addr hps_io upload request side
//   ioctl_din, ioctl_wait     returned byte and hold-off back to hps_io
//   pause_req, pause_ack      game core halt handshake
//   ram_addr, ram_rd, ram_dout byte-wide synchronous RAM read port
//   upload_done, byte_count   end-of-upload pulse and bytes served

module ioctl_upload_responder #(
  parameter logic [7:0] INDEX      = 8'd4,
  parameter int         ADDR_W     = 10,
  parameter int         SIZE       = 1024,
  parameter int         RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_dout,
  output logic              upload_done,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [1:0] {S_IDLE, S_PAUSE, S_READY, S_FETCH} state_t;

  localparam logic [24:0]   SIZE_L = 25'(SIZE);
  localparam logic [1:0]    LAT_L  = 2'(RD_LATENCY);
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [7:0]          din_q, din_d;
  logic                wait_q, wait_d;
  logic                pause_q, pause_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_rd_q, ram_rd_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [1:0]          lat_q, lat_d;
  // Set once READY is reached; decides whether an abort is a completed upload.
  logic                ready_seen_q, ready_seen_d;

  logic                active;
  logic                in_range;
  logic [ADDR_W:0]     count_inc;

  assign active    = ioctl_upload && (ioctl_index == INDEX);
  // Full 25-bit compare so any upper address bit lands out of range.
  assign in_range  = ioctl_addr < SIZE_L;
  assign count_inc = (&count_q) ? count_q : count_q + ONE;

  always_comb begin
    state_d      = state_q;
    din_d        = din_q;
    wait_d       = wait_q;
    pause_d      = pause_q;
    ram_addr_d   = ram_addr_q;
    ram_rd_d     = 1'b0;
    done_d       = 1'b0;
    count_d      = count_q;
    lat_d        = lat_q;
    ready_seen_d = ready_seen_q;

    if (state_q == S_IDLE) begin
      if (active) begin
        state_d      = S_PAUSE;
        pause_d      = 1'b1;
        wait_d       = 1'b1;
        count_d      = '0;
        ready_seen_d = 1'b0;
      end
    end else if (!active) begin
      // Abort from any busy state; an in-flight fetch is simply dropped.
      state_d = S_IDLE;
      pause_d = 1'b0;
      wait_d  = 1'b0;
      done_d  = ready_seen_q;
    end else begin
      case (state_q)
        S_PAUSE: begin
          if (pause_ack) begin
            state_d      = S_READY;
            wait_d       = 1'b0;
            ready_seen_d = 1'b1;
          end
        end
        S_READY: begin
          if (ioctl_rd) begin
            if (in_range) begin
              state_d    = S_FETCH;
              ram_addr_d = ioctl_addr[ADDR_W-1:0];
              ram_rd_d   = 1'b1;
              wait_d     = 1'b1;
              lat_d      = LAT_L;
            end else begin
              din_d   = 8'hFF;
              count_d = count_inc;
            end
          end
        end
        S_FETCH: begin
          if (lat_q == 2'd1) begin
            state_d = S_READY;
            din_d   = ram_dout;
            wait_d  = 1'b0;
            count_d = count_inc;
          end else begin
            lat_d = lat_q - 2'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      din_q        <= '0;
      wait_q       <= 1'b0;
      pause_q      <= 1'b0;
      ram_addr_q   <= '0;
      ram_rd_q     <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
      lat_q        <= '0;
      ready_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      wait_q       <= wait_d;
      pause_q      <= pause_d;
      ram_addr_q   <= ram_addr_d;
      ram_rd_q     <= ram_rd_d;
      done_q       <= done_d;
      count_q      <= count_d;
      lat_q        <= lat_d;
      ready_seen_q <= ready_seen_d;
    end
  end

  assign ioctl_din   = din_q;
  assign ioctl_wait  = wait_q;
  assign pause_req   = pause_q;
  assign ram_addr    = ram_addr_q;
  assign ram_rd      = ram_rd_q;
  assign upload_done = done_q;
  assign byte_count  = count_q;

endmodule

// File: doc/ioctl_upload_responder.md
Name: ioctl_upload_responder

Overview:
- Serves HPS upload requests (core → HPS) on the ioctl bus, the opposite direction of the ROM/DIP download path.
- Used for saving NVRAM and hiscore RAM from a game core.
- Pauses the game core while uploading, then reads a byte-wide synchronous RAM port for each requested address.
- Returns each byte on ioctl_din and paces the HPS with ioctl_wait.
- Sits between hps_io and the game core's RAM second port in the emu top level.

Parameters:
- INDEX, 8'd4, ioctl_index value this block answers to.
- ADDR_W, 10, RAM address width.
- SIZE, 1024, number of valid bytes; must be ≤ 2^ADDR_W.
- RD_LATENCY, 1, RAM read latency in cycles from registered ram_addr/ram_rd to valid ram_dout; legal values 1..3.

Ports:
- clk  in  1  system clock (clk_sys).
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_upload  in  1  upload in progress, from hps_io.
- ioctl_index  in  8  upload target index.
- ioctl_rd  in  1  one-cycle read strobe from hps_io.
- ioctl_addr  in  25  byte address of the read.
- ioctl_din  out  8  returned byte.
- ioctl_wait  out  1  holds hps_io off while high.
- pause_req  out  1  request to halt the game core.
- pause_ack  in  1  game core halted.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rd  out  1  one-cycle RAM read enable.
- ram_dout  in  8  RAM read data.
- upload_done  out  1  one-cycle pulse at end of a completed upload.
- byte_count  out  ADDR_W+1  bytes served in the current or last upload.

Behaviour:
- active = ioctl_upload && (ioctl_index == INDEX), evaluated combinationally each cycle.
- Reset (reset_n low, async):
  - State goes to IDLE.
  - ioctl_din=0, ioctl_wait=0, pause_req=0, ram_addr=0, ram_rd=0, upload_done=0, byte_count=0.
  - Reset mid-operation abandons the transfer; no done pulse.
- All outputs are registered.
- States: IDLE, PAUSE, READY, FETCH.
- IDLE:
  - On active=1: go to PAUSE; next cycle pause_req=1, ioctl_wait=1, byte_count=0.
- PAUSE:
  - Holds pause_req=1 and ioctl_wait=1.
  - On pause_ack=1: go to READY; ioctl_wait=0 next cycle.
  - ioctl_rd in PAUSE is ignored.
- READY (pause_req=1, ioctl_wait=0):
  - ioctl_rd with ioctl_addr < SIZE:
    - Next cycle: ram_addr=ioctl_addr[ADDR_W-1:0], ram_rd=1 for exactly one cycle, ioctl_wait=1, counter=RD_LATENCY.
    - Go to FETCH.
  - ioctl_rd with ioctl_addr ≥ SIZE (any upper address bit set counts):
    - Next cycle ioctl_din=8'hFF and byte_count increments.
    - No RAM access, ioctl_wait stays 0, stay in READY.
- FETCH:
  - Each cycle: if counter==1, latch ram_dout into ioctl_din, set ioctl_wait=0, increment byte_count, return to READY; otherwise decrement counter.
  - Cycle numbering: ioctl_rd sampled in cycle 0 → ram_rd high in cycle 1 → ram_dout sampled at the end of cycle RD_LATENCY.
  - ioctl_din valid and ioctl_wait low from cycle RD_LATENCY+1.
  - ioctl_wait is high for exactly RD_LATENCY cycles.
  - ioctl_rd during FETCH is a protocol violation: ignored, no count, no second RAM read.
- ioctl_din holds its last value between reads, after upload end, and after abort.
- byte_count saturates at all-ones; it never wraps.
- active falls in any non-IDLE state:
  - Go to IDLE next cycle; pause_req=0, ioctl_wait=0, ram_rd=0.
  - An in-flight FETCH is discarded; its byte is not counted.
  - upload_done pulses for one cycle only if READY was reached during this upload. Abort from PAUSE gives no pulse.
- ioctl_index changing mid-upload is treated as active falling.
- active held high continuously never re-enters PAUSE; a new upload needs active to fall and rise again.
- pause_ack dropping while in READY or FETCH has no effect; pause_req stays asserted.

Test Plan:
- Reset and idle: reset_n low with ioctl_rd toggling → all outputs 0. Release with active=0 → stays idle; ram_rd never asserts.
- Pause handshake: INDEX=4, set ioctl_index=4, ioctl_upload=1, pause_ack delayed 5 cycles → pause_req and ioctl_wait high from next cycle. ioctl_wait drops the cycle after the cycle in which pause_ack is sampled. No ram_rd during PAUSE, even with ioctl_rd pulsed.
- In-range read latency:
  - RD_LATENCY=1, RAM[0x012]=8'hA5, ioctl_rd with addr 0x12 → ram_rd one cycle with ram_addr=0x12, ioctl_wait high 1 cycle, ioctl_din=A5, byte_count=1.
  - Repeat with RD_LATENCY=3 → ioctl_wait high exactly 3 cycles.
- Out-of-range: SIZE=1024, ioctl_rd at addr 0x400 and at 0x1000400 → ioctl_din=FF, ioctl_wait never rises, no ram_rd, byte_count increments each time.
- Full sweep and done:
  - Read addresses 0..1023 back-to-back, waiting for ioctl_wait low each time, against a RAM pattern where RAM[addr]=addr^8'h5A.
  - Every byte matches; byte_count=1024.
  - Drop ioctl_upload → upload_done single pulse, pause_req low next cycle.
- Abort cases:
  - Drop ioctl_upload mid-FETCH → no count increment, ioctl_wait low, upload_done pulses.
  - Drop it during PAUSE → no upload_done.
  - Assert reset_n low mid-FETCH → immediate IDLE with all outputs 0.
